// File: rtl/spi_xfer_pkg.sv
// Shared types and defaults for the SPI transfer sequencer: FSM state encoding,
// default sizing, and the FIFO pointer-width helper.
package spi_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ACTIVE,
    CAPTURE,
    GAP
  } xfer_state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_GAP     = 2;
  localparam int DEF_TIMEOUT = 63;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// Producer/consumer stream bundle of the SPI transfer sequencer: TX words in, RX words out.
interface spi_xfer_sequencer_if
  import spi_xfer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push while full is accepted only
// when a pop retires the head in the same cycle.
module spi_sync_fifo
  import spi_xfer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW:0]       r_wr_ptr;
  logic [PW:0]       r_rd_ptr;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rd_ptr[PW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Feeds one SPI transaction per queued TX word and queues each received word for the consumer.
// Optional watchdog enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_sequencer
  import spi_xfer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int GAP     = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  spi_xfer_sequencer_if.slave  io_stream,
  output logic [DATA_W-1:0]    o_data_send_c,
  output logic                 o_start_comm,
  input  logic                 i_cs,
  input  logic [DATA_W-1:0]    i_cipo_register,
  output logic                 o_busy,
  output logic                 o_timeout_err
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  xfer_state_e       r_state;
  xfer_state_e       w_next_state;
  logic [DATA_W-1:0] r_data_send;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              w_gap_done;
  logic              w_wdog_hit;
  logic              w_start_comm;

  logic              w_tx_push;
  logic              w_tx_pop;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic [DATA_W-1:0] w_tx_rdata;
  logic              w_rx_push;
  logic              w_rx_pop;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic [DATA_W-1:0] w_rx_wdata;
  logic [DATA_W-1:0] w_rx_rdata;

  assign io_stream.tx_ready = !w_tx_full && !i_rst;
  assign io_stream.rx_valid = !w_rx_empty;
  assign io_stream.rx_data  = w_rx_rdata;
  assign w_tx_push          = io_stream.tx_valid && io_stream.tx_ready;
  assign w_rx_pop           = io_stream.rx_valid && io_stream.rx_ready;

  spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_wdata (io_stream.tx_data),
    .o_rdata (w_tx_rdata),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_wdata (w_rx_wdata),
    .o_rdata (w_rx_rdata),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout_err;

  assign w_wdog_hit    = ((r_state == LAUNCH) || (r_state == ACTIVE)) &&
                         (r_wdog == WDOG_W'(TIMEOUT - 1));
  assign o_timeout_err = r_timeout_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_tx_pop)
        r_wdog <= '0;
      else if ((r_state == LAUNCH) || (r_state == ACTIVE))
        r_wdog <= r_wdog + 1'b1;
      if (w_wdog_hit) r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_wdog_hit    = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  assign w_gap_done = (r_gap_cnt == GAP_W'(GAP - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // A launch reserves its RX slot up front, so CAPTURE never sees a full RX FIFO.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_next_state = r_state;
    w_tx_pop     = 1'b0;
    w_rx_push    = 1'b0;
    w_rx_wdata   = i_cipo_register;
    w_start_comm = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_tx_empty && !w_rx_full) begin
          w_next_state = LAUNCH;
          w_tx_pop     = 1'b1;
        end
      end
      LAUNCH: begin
        w_start_comm = 1'b1;
        if (!i_cs) w_next_state = ACTIVE;
      end
      ACTIVE: begin
        if (i_cs) w_next_state = CAPTURE;
      end
      CAPTURE: begin
        w_rx_push    = 1'b1;
        w_next_state = (GAP == 0) ? IDLE : spi_xfer_pkg::GAP;
      end
      spi_xfer_pkg::GAP: begin
        if (w_gap_done) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    // A timed-out transaction still yields one RX word so TX and RX order stay paired.
    if (w_wdog_hit) begin
      w_start_comm = 1'b0;
      w_rx_push    = 1'b1;
      w_rx_wdata   = '0;
      w_next_state = (GAP == 0) ? IDLE : spi_xfer_pkg::GAP;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_send <= '0;
      r_gap_cnt   <= '0;
    end else begin
      if (w_tx_pop) r_data_send <= w_tx_rdata;
      r_gap_cnt <= (r_state == spi_xfer_pkg::GAP) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  assign o_data_send_c = r_data_send;
  assign o_start_comm  = w_start_comm;
  assign o_busy        = (r_state != IDLE) || !w_tx_empty;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Randomized bench for spi_xfer_sequencer with a behavioural SPI controller stub and
// queue-based scoreboard; the timeout scenario runs when SPI_XFER_TIMEOUT_EN is defined.
module tb_spi_xfer_sequencer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int GAP    = 2;
`ifdef SPI_XFER_TIMEOUT_EN
  localparam int TIMEOUT = 10;
`else
  localparam int TIMEOUT = 63;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data_send_c;
  logic              start_comm;
  logic              cs;
  logic [DATA_W-1:0] cipo;
  logic              busy;
  logic              timeout_err;

  spi_xfer_sequencer_if #(.DATA_W(DATA_W)) u_if ();

  spi_xfer_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .GAP    (GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .io_stream       (u_if),
    .o_data_send_c   (data_send_c),
    .o_start_comm    (start_comm),
    .i_cs            (cs),
    .i_cipo_register (cipo),
    .o_busy          (busy),
    .o_timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] tx_model [$];
  logic [DATA_W-1:0] rx_model [$];
  int n_launch = 0;
  int n_rx     = 0;
  int n_start  = 0;
  int cyc      = 0;
  int last_cs_rise = -1;
  bit stub_hold   = 1'b0;
  bit gap_chk_en  = 1'b0;
  logic start_prev = 1'b0;
  logic cs_prev    = 1'b1;

  // Output monitor: counts start pulses, checks RX beats against the expected queue.
  always @(negedge clk) begin
    logic [DATA_W-1:0] exp_w;
    cyc++;
    if (!rst) begin
      if (start_comm && !start_prev) begin
        n_start++;
        if (gap_chk_en && last_cs_rise >= 0) begin
          checks++;
          if (cyc - last_cs_rise <= GAP) begin
            errors++;
            $display("FAIL gap: %0d cycles from cs rise to start_comm, need more than %0d",
                     cyc - last_cs_rise, GAP);
          end
        end
      end
      if (cs && !cs_prev) last_cs_rise = cyc;
      if (u_if.rx_valid && u_if.rx_ready) begin
        checks++;
        n_rx++;
        if (rx_model.size() == 0) begin
          errors++;
          $display("FAIL rx_extra: unexpected rx word %0h", u_if.rx_data);
        end else begin
          exp_w = rx_model.pop_front();
          if (u_if.rx_data !== exp_w) begin
            errors++;
            $display("FAIL rx_data: got %0h expected %0h", u_if.rx_data, exp_w);
          end
        end
      end
    end
    start_prev = start_comm;
    cs_prev    = cs;
  end

  // SPI controller stub: answers start_comm with a CS-low window and a random received word.
  initial begin
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] exp_w;
    logic [DATA_W-1:0] resp;
    int d;
    cs   = 1'b1;
    cipo = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && !stub_hold && start_comm) begin
        d = $urandom_range(0, 2);
        for (int i = 0; i < d && !rst; i++) begin @(posedge clk); #1; end
        if (!rst) begin
          word = data_send_c;
          cs   = 1'b0;
          n_launch++;
          checks++;
          if (tx_model.size() == 0) begin
            errors++;
            $display("FAIL launch_extra: launched %0h with nothing queued", word);
          end else begin
            exp_w = tx_model.pop_front();
            if (word !== exp_w) begin
              errors++;
              $display("FAIL launch_word: got %0h expected %0h", word, exp_w);
            end
          end
          d = $urandom_range(1, 4);
          for (int i = 0; i < d && !rst; i++) begin @(posedge clk); #1; end
          if (!rst) begin
            checks++;
            if (data_send_c !== word) begin
              errors++;
              $display("FAIL send_hold: got %0h expected %0h", data_send_c, word);
            end
            resp = DATA_W'($urandom);
            cipo = resp;
            rx_model.push_back(resp);
          end
          cs = 1'b1;
        end
      end
    end
  end

  task automatic sync_edge();
    @(posedge clk); #1;
  endtask

  // Caller must be at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_word(input logic [DATA_W-1:0] w, output int stalls);
    int n;
    stalls = 0;
    u_if.tx_data  = w;
    u_if.tx_valid = 1'b1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (u_if.tx_ready) break;
      stalls++;
    end
    if (n == 500) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %0h never accepted", w);
    end else begin
      tx_model.push_back(w);
    end
    @(posedge clk); #1;
    u_if.tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int budget, input string tag);
    int n;
    for (n = 0; n < budget && n_rx < target; n++) @(negedge clk);
    if (n_rx < target) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: rx count %0d expected %0d", tag, n_rx, target);
    end
  endtask

  task automatic expect1(input string name, input logic got, input logic exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp_v);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    expect1("reset_tx_ready", u_if.tx_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    expect1("reset_tx_ready_after", u_if.tx_ready, 1'b1);
    expect1("reset_rx_valid", u_if.rx_valid, 1'b0);
    expect1("reset_start_comm", start_comm, 1'b0);
    expect1("reset_busy", busy, 1'b0);
    expect1("reset_timeout_err", timeout_err, 1'b0);
    checks++;
    if (data_send_c !== '0) begin
      errors++;
      $display("FAIL reset_data_send: got %0h expected 0", data_send_c);
    end
  endtask

  task automatic test_single();
    int s0, r0, st;
    sync_edge();
    u_if.rx_ready = 1'b1;
    s0 = n_start;
    r0 = n_rx;
    push_word(8'hA5, st);
    @(negedge clk);
    expect1("single_latency_early", start_comm, 1'b0);
    @(negedge clk);
    expect1("single_latency_launch", start_comm, 1'b1);
    wait_rx(r0 + 1, 200, "single");
    repeat (8) @(negedge clk);
    expect_int("single_start_pulses", n_start - s0, 1);
    expect_int("single_rx_beats", n_rx - r0, 1);
    expect1("single_rx_valid_after", u_if.rx_valid, 1'b0);
    expect1("single_busy_after", busy, 1'b0);
  endtask

  task automatic test_burst();
    int s0, r0, l0, st;
    sync_edge();
    u_if.rx_ready = 1'b1;
    last_cs_rise = -1;
    gap_chk_en = 1'b1;
    s0 = n_start;
    r0 = n_rx;
    l0 = n_launch;
    for (int i = 1; i <= 4; i++) push_word(DATA_W'(i), st);
    wait_rx(r0 + 4, 400, "burst");
    repeat (8) @(negedge clk);
    gap_chk_en = 1'b0;
    expect_int("burst_start_pulses", n_start - s0, 4);
    expect_int("burst_launches", n_launch - l0, 4);
  endtask

  task automatic test_backpressure();
    int r0, l0, st, stall_total;
    sync_edge();
    u_if.rx_ready = 1'b0;
    r0 = n_rx;
    l0 = n_launch;
    stall_total = 0;
    for (int i = 0; i < 6; i++) begin
      push_word(DATA_W'($urandom), st);
      stall_total += st;
    end
    checks++;
    if (stall_total == 0) begin
      errors++;
      $display("FAIL bp_tx_ready_drop: got 0 stalled cycles expected at least 1");
    end
    repeat (60) @(negedge clk);
    expect_int("bp_launches_held", n_launch - l0, 4);
    expect_int("bp_rx_none", n_rx - r0, 0);
    expect1("bp_busy", busy, 1'b1);
    expect1("bp_start_idle", start_comm, 1'b0);
    expect1("bp_rx_valid", u_if.rx_valid, 1'b1);
    sync_edge();
    u_if.rx_ready = 1'b1;
    wait_rx(r0 + 6, 600, "bp");
    repeat (8) @(negedge clk);
    expect_int("bp_launches_all", n_launch - l0, 6);
    expect1("bp_busy_done", busy, 1'b0);
  endtask

  task automatic test_spurious();
    int r0, s0;
    repeat (4) @(negedge clk);
    r0 = n_rx;
    s0 = n_start;
    sync_edge();
    cs = 1'b0;
    repeat (3) begin
      @(negedge clk);
      expect1("spurious_busy_low", busy, 1'b0);
      sync_edge();
    end
    cs = 1'b1;
    repeat (6) @(negedge clk);
    expect_int("spurious_rx", n_rx - r0, 0);
    expect_int("spurious_start", n_start - s0, 0);
    expect1("spurious_rx_valid", u_if.rx_valid, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n, r0, st;
    sync_edge();
    u_if.rx_ready = 1'b1;
    push_word(8'hC3, st);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cs === 1'b0) break;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL rmid_cs_low: cs never went low");
    end
    rst = 1'b1;
    @(negedge clk);
    expect1("rmid_start_in_reset", start_comm, 1'b0);
    expect1("rmid_rx_valid_in_reset", u_if.rx_valid, 1'b0);
    expect1("rmid_tx_ready_in_reset", u_if.tx_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    expect1("rmid_start_after", start_comm, 1'b0);
    expect1("rmid_rx_valid_after", u_if.rx_valid, 1'b0);
    expect1("rmid_tx_ready_after", u_if.tx_ready, 1'b1);
    expect1("rmid_busy_after", busy, 1'b0);
    checks++;
    if (data_send_c !== '0) begin
      errors++;
      $display("FAIL rmid_data_send: got %0h expected 0", data_send_c);
    end
    tx_model.delete();
    rx_model.delete();
    r0 = n_rx;
    sync_edge();
    push_word(8'h5A, st);
    wait_rx(r0 + 1, 200, "rmid");
    repeat (6) @(negedge clk);
    expect_int("rmid_rx_count", n_rx - r0, 1);
    checks++;
    if (data_send_c !== 8'h5A) begin
      errors++;
      $display("FAIL rmid_last_sent: got %0h expected 5a", data_send_c);
    end
  endtask

  task automatic test_random();
    int r0, target;
    r0 = n_rx;
    target = r0 + 24;
    sync_edge();
    fork
      begin
        int st;
        for (int i = 0; i < 24; i++) begin
          push_word(DATA_W'($urandom), st);
          repeat ($urandom_range(0, 3)) sync_edge();
        end
      end
      begin
        for (int c = 0; c < 4000 && n_rx < target; c++) begin
          sync_edge();
          u_if.rx_ready = 1'($urandom_range(0, 1));
        end
        u_if.rx_ready = 1'b1;
      end
    join
    wait_rx(target, 400, "random");
    repeat (8) @(negedge clk);
    expect_int("random_rx_count", n_rx - r0, 24);
    expect_int("random_tx_left", tx_model.size(), 0);
    expect_int("random_rx_left", rx_model.size(), 0);
    expect1("random_busy_done", busy, 1'b0);
  endtask

`ifdef SPI_XFER_TIMEOUT_EN
  task automatic test_timeout();
    int n, c, r0, st;
    logic [DATA_W-1:0] dropped;
    sync_edge();
    u_if.rx_ready = 1'b1;
    stub_hold = 1'b1;
    r0 = n_rx;
    push_word(8'h77, st);
    push_word(8'h88, st);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (start_comm) break;
    end
    dropped = tx_model.pop_front();
    rx_model.push_back('0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!timeout_err && c < 200);
    expect_int("timeout_latency", c, TIMEOUT);
    expect1("timeout_start_dropped", start_comm, 1'b0);
    stub_hold = 1'b0;
    wait_rx(r0 + 2, 300, "timeout");
    repeat (6) @(negedge clk);
    expect_int("timeout_rx_count", n_rx - r0, 2);
    expect1("timeout_sticky", timeout_err, 1'b1);
    checks++;
    if (dropped !== 8'h77) begin
      errors++;
      $display("FAIL timeout_order: got %0h expected 77", dropped);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "global timeout");
  end

  initial begin
    u_if.tx_data  = '0;
    u_if.tx_valid = 1'b0;
    u_if.rx_ready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    test_random();
`ifdef SPI_XFER_TIMEOUT_EN
    test_timeout();
`else
    expect1("timeout_err_tied", timeout_err, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
